alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the datapath: the successor to the single-cycle 16-bit ALU, with configurable width, a 3-bit opcode adding shifts and an iterative multiply, registered outputs, and a start/busy/done handshake. The controller FSM issues one operation per `start` and samples `out`/`status_out` on `done`. Single-cycle ops complete in one clock; MUL completes in WIDTH clocks.

## Interface
- `WIDTH`, 16, operand/result width in bits; legal values are powers of two, 4..64.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  issue request; sampled on each rising edge.
- `ALUop`  in  3  opcode, sampled with `start`.
- `Ain`  in  WIDTH  operand A, sampled with `start`.
- `Bin`  in  WIDTH  operand B, sampled with `start`.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse; `out`/`status_out` hold the new result.
- `out`  out  WIDTH  registered result; holds until the next completion.
- `status_out`  out  3  registered flags: [0]=N, [1]=V, [2]=Z.

## Operation
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND: A&B.
  - 011 NOT: ~B.
  - 100 MUL: unsigned A×B, low WIDTH bits.
  - 101 LSL: A<<s.
  - 110 LSR: A>>s, logical.
  - 111 ASR: A>>s, arithmetic.
- Shift count `s` = `Bin[$clog2(WIDTH)-1:0]`; upper bits of `Bin` are ignored. A shift of 0 returns A.
- All arithmetic is modulo 2^WIDTH. No carry output.
- Flags are computed on the final result:
  - N = `out[WIDTH-1]`.
  - Z = (`out` == 0).
  - V for ADD: A and B have equal signs and the result sign differs.
  - V for SUB: A and B signs differ and the result sign differs from A.
  - V for MUL: the upper WIDTH bits of the full 2·WIDTH product are nonzero.
  - V for AND/NOT/shifts: 0.
- States:
  - IDLE: `busy`=0. On `start` with op≠MUL, register the result and flags and pulse `done`; stay in IDLE. On `start` with MUL, latch A and B, clear the 2·WIDTH accumulator, load the iteration counter with WIDTH, and go to MUL.
  - MUL: `busy`=1. Each cycle, if the LSB of the multiplier is 1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; decrement the counter. On the final iteration, write `out` = low half, write flags, pulse `done`, and return to IDLE.
- `start` while `busy`=1 is ignored: operands are not sampled and the in-flight MUL is undisturbed.
- Reset (any time, including mid-MUL): state=IDLE; `busy`=0, `done`=0, `out`=0, `status_out`=3'b000; internal registers cleared. An interrupted MUL produces no `done`.

## Timing
- `start` sampled at edge k, non-MUL op: `out`, `status_out` valid and `done`=1 after edge k; `done` deasserts after edge k+1 unless another op is issued.
- `start` sampled at edge k, MUL: `busy`=1 after edge k, through edge k+WIDTH−1. After edge k+WIDTH: `busy`=0, `done`=1, result valid. Latency is exactly WIDTH cycles.
- Back-to-back: `start` is accepted in the same cycle `done`=1 (state is IDLE). Consecutive single-cycle ops give `done` high on consecutive cycles.
- `out`/`status_out` change only on a `done` edge or on reset. During MUL they retain the previous result.
- Operand/opcode changes after the sampling edge have no effect.

## Test plan
- Reset, then ADD 0x7FFF+0x0001 (WIDTH=16): one cycle later, `out`=0x8000, `status_out`=3'b011, `done` pulses for exactly one cycle, `busy` stays 0.
- SUB 0x0005−0x0005 → `out`=0x0000, `status_out`=3'b100. Issued back-to-back with SUB 0x8000−0x0001 → next cycle `out`=0x7FFF, `status_out`=3'b010. `done` is high on two consecutive cycles.
- MUL 0x0012×0x0034: `busy` high for exactly 16 cycles, then `out`=0x03A8, `status_out`=3'b000, `done` pulses. Then MUL 0x0100×0x0100 → `out`=0x0000, `status_out`=3'b110.
- Shifts on A=0x8000, Bin=0x0014 (s=4): ASR → 0xF800, `status_out`=3'b001; LSR → 0x0800, 3'b000. LSL A=0x0001, Bin=0x000F → 0x8000, 3'b001. NOT B=0xFFFF → 0x0000, 3'b100.
- During MUL 0x0003×0x0003, assert `start` with ADD 0x0001+0x0001 at cycle 5: the ADD is ignored, and MUL completes on schedule with `out`=0x0009 and a single `done` pulse.
- Assert `reset` at cycle 8 of a MUL: `busy`, `done`, `out` and `status_out` go to 0 immediately (asynchronously) and no `done` follows. After release, ADD 0x0002+0x0003 → `out`=0x0005. Repeat the ADD and MUL checks with WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
// Issue/result bundle between the datapath controller and the multi-cycle ALU.
//
//   start      controller -> ALU   issue request, sampled on each rising edge
//   ALUop      controller -> ALU   3-bit opcode, sampled with start
//   Ain, Bin   controller -> ALU   operands, sampled with start
//   busy       ALU -> controller   multi-cycle operation in progress
//   done       ALU -> controller   one-cycle pulse, out/status_out hold new result
//   out        ALU -> controller   registered result
//   status_out ALU -> controller   registered flags {Z, V, N}
//
// modport master: the controller side.  modport slave: the ALU side.
// -----------------------------------------------------------------------------
interface alu_mc_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [2:0]       ALUop;
   logic [WIDTH-1:0] Ain;
   logic [WIDTH-1:0] Bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic [2:0]       status_out;

   modport master (
      output start, ALUop, Ain, Bin,
      input  busy, done, out, status_out
   );

   modport slave (
      input  start, ALUop, Ain, Bin,
      output busy, done, out, status_out
   );
endinterface

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Parametrised multi-cycle ALU. ADD/SUB/AND/NOT/LSL/LSR/ASR complete in one
// clock; MUL is an iterative shift-and-add taking exactly WIDTH clocks. Result
// and flags are registered and change only when done pulses (or on reset).
//
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    alu_mc_if.slave: start/ALUop/Ain/Bin in, busy/done/out/status_out out
//
// WIDTH must be a power of two in 4..64.
// -----------------------------------------------------------------------------
module alu_mc #(
   parameter int WIDTH = 16
) (
   input  logic     clk,
   input  logic     reset,
   alu_mc_if.slave  bus
);
   localparam int SW = $clog2(WIDTH);   // shift-count width
   localparam int CW = SW + 1;          // counter must hold the value WIDTH

   typedef enum logic { ST_IDLE, ST_MUL } state_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_NOT = 3'b011,
      OP_MUL = 3'b100,
      OP_LSL = 3'b101,
      OP_LSR = 3'b110,
      OP_ASR = 3'b111
   } op_t;

   state_t             state_q,  state_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;    // multiplicand, shifts left
   logic [WIDTH-1:0]   mplier_q, mplier_d;   // multiplier, shifts right
   logic [2*WIDTH-1:0] acc_q,    acc_d;      // full-width partial product
   logic [CW-1:0]      cnt_q,    cnt_d;      // iterations remaining
   logic [WIDTH-1:0]   out_q,    out_d;
   logic [2:0]         status_q, status_d;
   logic               done_q,   done_d;

   // Single-cycle result path
   logic [WIDTH-1:0]   alu_r;
   logic               alu_v;
   logic [SW-1:0]      shamt;
   logic [2*WIDTH-1:0] acc_step;

   assign shamt    = bus.Bin[SW-1:0];
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the case statements can leave it unassigned and infer a latch.
   always_comb begin
      alu_r = '0;
      alu_v = 1'b0;
      case (op_t'(bus.ALUop))
         OP_ADD: begin
            alu_r = bus.Ain + bus.Bin;
            alu_v = (bus.Ain[WIDTH-1] == bus.Bin[WIDTH-1]) &&
                    (alu_r[WIDTH-1] != bus.Ain[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r = bus.Ain - bus.Bin;
            alu_v = (bus.Ain[WIDTH-1] != bus.Bin[WIDTH-1]) &&
                    (alu_r[WIDTH-1] != bus.Ain[WIDTH-1]);
         end
         OP_AND: alu_r = bus.Ain & bus.Bin;
         OP_NOT: alu_r = ~bus.Bin;
         OP_LSL: alu_r = bus.Ain << shamt;
         OP_LSR: alu_r = bus.Ain >> shamt;
         OP_ASR: alu_r = $signed(bus.Ain) >>> shamt;
         default: alu_r = '0;   // MUL goes through the iterative path
      endcase
   end

   // Next-state and register-update logic
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      status_d = status_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (op_t'(bus.ALUop) == OP_MUL) begin
                  mcand_d  = {{WIDTH{1'b0}}, bus.Ain};
                  mplier_d = bus.Bin;
                  acc_d    = '0;
                  cnt_d    = CW'(WIDTH);
                  state_d  = ST_MUL;
               end else begin
                  out_d    = alu_r;
                  status_d = {alu_r == '0, alu_v, alu_r[WIDTH-1]};
                  done_d   = 1'b1;
               end
            end
         end
         ST_MUL: begin
            // start is not looked at here, so requests while busy are dropped
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               out_d    = acc_step[WIDTH-1:0];
               status_d = {acc_step[WIDTH-1:0] == '0,
                           |acc_step[2*WIDTH-1:WIDTH],
                           acc_step[WIDTH-1]};
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
         status_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         status_q <= status_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy       = (state_q == ST_MUL);
   assign bus.done       = done_q;
   assign bus.out        = out_q;
   assign bus.status_out = status_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
// Drives alu_mc at WIDTH = 8, 16 and 32 with directed vectors. Each issued
// operation pushes its hand-computed result, flags and completion cycle into a
// per-width queue; monitors pop and compare whenever done is seen.
// -----------------------------------------------------------------------------
module tb_alu_mc;
   typedef struct {
      logic [63:0] out;
      logic [2:0]  st;
      int          cyc;
      string       name;
   } exp_t;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, NOT_ = 3'b011,
                          MUL = 3'b100, LSL = 3'b101, LSR  = 3'b110, ASR  = 3'b111;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   exp_t q8[$], q16[$], q32[$];
   int   run8 = 0, run16 = 0, run32 = 0;
   int   last8 = 0, last16 = 0, last32 = 0;

   alu_mc_if #(.WIDTH(8))  b8 ();
   alu_mc_if #(.WIDTH(16)) b16 ();
   alu_mc_if #(.WIDTH(32)) b32 ();

   alu_mc #(.WIDTH(8))  u_alu8  (.clk(clk), .reset(reset), .bus(b8));
   alu_mc #(.WIDTH(16)) u_alu16 (.clk(clk), .reset(reset), .bus(b16));
   alu_mc #(.WIDTH(32)) u_alu32 (.clk(clk), .reset(reset), .bus(b32));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Pop the oldest expectation for this width and compare against the DUT.
   task automatic score(input int w, input logic [63:0] out_v, input logic [2:0] st_v);
      exp_t e;
      int   n;
      n = (w == 8) ? q8.size() : (w == 16) ? q16.size() : q32.size();
      check($sformatf("w%0d done expected", w), 64'(n != 0), 64'd1);
      if (n != 0) begin
         case (w)
            8:       e = q8.pop_front();
            16:      e = q16.pop_front();
            default: e = q32.pop_front();
         endcase
         check({e.name, " out"},    out_v,         e.out);
         check({e.name, " status"}, 64'(st_v),     64'(e.st));
         check({e.name, " cycle"},  64'(cyc),      64'(e.cyc));
      end
   endtask

   always @(negedge clk) if (!reset && b8.done)  score(8,  64'(b8.out),  b8.status_out);
   always @(negedge clk) if (!reset && b16.done) score(16, 64'(b16.out), b16.status_out);
   always @(negedge clk) if (!reset && b32.done) score(32, 64'(b32.out), b32.status_out);

   // Length of the most recent busy run, per width
   always @(negedge clk) begin
      if (b8.busy) run8 <= run8 + 1;
      else if (run8 != 0) begin last8 <= run8; run8 <= 0; end
      if (b16.busy) run16 <= run16 + 1;
      else if (run16 != 0) begin last16 <= run16; run16 <= 0; end
      if (b32.busy) run32 <= run32 + 1;
      else if (run32 != 0) begin last32 <= run32; run32 <= 0; end
   end

   task automatic issue(input int w, input string name, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_o, input logic [2:0] exp_s,
                        input bit push);
      exp_t e;
      @(negedge clk);
      e.out  = exp_o;
      e.st   = exp_s;
      e.name = name;
      e.cyc  = cyc + 1 + ((op == MUL) ? w : 0);
      case (w)
         8: begin
            b8.start = 1'b1; b8.ALUop = op; b8.Ain = a[7:0]; b8.Bin = b[7:0];
            if (push) q8.push_back(e);
         end
         16: begin
            b16.start = 1'b1; b16.ALUop = op; b16.Ain = a[15:0]; b16.Bin = b[15:0];
            if (push) q16.push_back(e);
         end
         default: begin
            b32.start = 1'b1; b32.ALUop = op; b32.Ain = a[31:0]; b32.Bin = b[31:0];
            if (push) q32.push_back(e);
         end
      endcase
   endtask

   // Drop start and scramble operands: nothing after the sampling edge matters.
   task automatic idle();
      @(negedge clk);
      b8.start  = 1'b0; b8.ALUop  = ADD; b8.Ain  = '1; b8.Bin  = '1;
      b16.start = 1'b0; b16.ALUop = ADD; b16.Ain = '1; b16.Bin = '1;
      b32.start = 1'b0; b32.ALUop = ADD; b32.Ain = '1; b32.Bin = '1;
   endtask

   task automatic drain(input int budget);
      int i = 0;
      while ((q8.size() + q16.size() + q32.size()) != 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      @(negedge clk);
      check("scoreboard drained", 64'(q8.size() + q16.size() + q32.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      b8.start  = 1'b0; b8.ALUop  = '0; b8.Ain  = '0; b8.Bin  = '0;
      b16.start = 1'b0; b16.ALUop = '0; b16.Ain = '0; b16.Bin = '0;
      b32.start = 1'b0; b32.ALUop = '0; b32.Ain = '0; b32.Bin = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst w8 busy",    64'(b8.busy),        64'd0);
      check("rst w8 done",    64'(b8.done),        64'd0);
      check("rst w8 out",     64'(b8.out),         64'd0);
      check("rst w8 status",  64'(b8.status_out),  64'd0);
      check("rst w16 busy",   64'(b16.busy),       64'd0);
      check("rst w16 done",   64'(b16.done),       64'd0);
      check("rst w16 out",    64'(b16.out),        64'd0);
      check("rst w16 status", 64'(b16.status_out), 64'd0);
      check("rst w32 busy",   64'(b32.busy),       64'd0);
      check("rst w32 out",    64'(b32.out),        64'd0);
      reset = 1'b0;

      // ADD with signed overflow; done is a single-cycle pulse, busy stays low
      issue(16, "add16 7fff+1", ADD, 64'h7FFF, 64'h0001, 64'h8000, 3'b011, 1'b1);
      idle();
      check("add16 done high", 64'(b16.done), 64'd1);
      check("add16 busy low",  64'(b16.busy), 64'd0);
      @(negedge clk);
      check("add16 done pulse ends", 64'(b16.done), 64'd0);

      // Back-to-back SUBs: done on consecutive cycles (checked via cycle stamp)
      issue(16, "sub16 5-5",    SUB, 64'h0005, 64'h0005, 64'h0000, 3'b100, 1'b1);
      issue(16, "sub16 8000-1", SUB, 64'h8000, 64'h0001, 64'h7FFF, 3'b010, 1'b1);
      issue(16, "and16",        AND_, 64'hF0F0, 64'h3C3C, 64'h3030, 3'b000, 1'b1);
      issue(16, "asr16 s4",     ASR, 64'h8000, 64'h0014, 64'hF800, 3'b001, 1'b1);
      issue(16, "lsr16 s4",     LSR, 64'h8000, 64'h0014, 64'h0800, 3'b000, 1'b1);
      issue(16, "lsl16 s15",    LSL, 64'h0001, 64'h000F, 64'h8000, 3'b001, 1'b1);
      issue(16, "not16 ffff",   NOT_, 64'h1234, 64'hFFFF, 64'h0000, 3'b100, 1'b1);
      issue(16, "lsl16 s0",     LSL, 64'h1234, 64'h0010, 64'h1234, 3'b000, 1'b1);
      idle();
      drain(10);

      // MUL latency and overflow
      issue(16, "mul16 12x34", MUL, 64'h0012, 64'h0034, 64'h03A8, 3'b000, 1'b1);
      idle();
      drain(40);
      check("mul16 busy cycles", 64'(last16), 64'd16);
      issue(16, "mul16 100x100", MUL, 64'h0100, 64'h0100, 64'h0000, 3'b110, 1'b1);
      idle();
      drain(40);
      check("mul16 ovf busy cycles", 64'(last16), 64'd16);

      // start while busy is ignored; MUL finishes on schedule
      issue(16, "mul16 3x3", MUL, 64'h0003, 64'h0003, 64'h0009, 3'b000, 1'b1);
      idle();
      repeat (3) @(negedge clk);
      issue(16, "stray add", ADD, 64'h0001, 64'h0001, 64'h0002, 3'b000, 1'b0);
      idle();
      drain(40);

      // Reset mid-MUL: outputs clear asynchronously and no done follows
      issue(16, "mul16 aborted", MUL, 64'h00FF, 64'h0101, 64'h0000, 3'b000, 1'b0);
      idle();
      repeat (6) @(negedge clk);
      check("mul16 busy mid-op",   64'(b16.busy), 64'd1);
      check("out held during mul", 64'(b16.out),  64'h0009);
      #2 reset = 1'b1;
      #1;
      check("async rst busy",   64'(b16.busy),       64'd0);
      check("async rst done",   64'(b16.done),       64'd0);
      check("async rst out",    64'(b16.out),        64'd0);
      check("async rst status", 64'(b16.status_out), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      issue(16, "add16 2+3", ADD, 64'h0002, 64'h0003, 64'h0005, 3'b000, 1'b1);
      idle();
      drain(10);

      // WIDTH = 8
      issue(8, "add8 7f+1", ADD, 64'h7F, 64'h01, 64'h80, 3'b011, 1'b1);
      issue(8, "mul8 0fx11", MUL, 64'h0F, 64'h11, 64'hFF, 3'b001, 1'b1);
      idle();
      drain(30);
      check("mul8 busy cycles", 64'(last8), 64'd8);
      issue(8, "mul8 10x10", MUL, 64'h10, 64'h10, 64'h00, 3'b110, 1'b1);
      idle();
      drain(30);

      // WIDTH = 32
      issue(32, "add32 7fffffff+1", ADD, 64'h7FFF_FFFF, 64'h1, 64'h8000_0000, 3'b011, 1'b1);
      issue(32, "mul32 12345x100", MUL, 64'h0001_2345, 64'h0000_0100, 64'h0123_4500, 3'b000, 1'b1);
      idle();
      drain(60);
      check("mul32 busy cycles", 64'(last32), 64'd32);
      issue(32, "mul32 10000x10000", MUL, 64'h0001_0000, 64'h0001_0000, 64'h0, 3'b110, 1'b1);
      idle();
      drain(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
